ct_case_counter: RTL and testbench
==================================

Name: ct_case_counter

Overview:
- 3-bit synchronous sequence counter whose next state comes from an explicit case table, not an adder.
- Standalone leaf block used as a small count/sequence source (LED driver, state tick) in the BehavDesc designs.
- Parameter selects one of four fixed count sequences.
- Single clock domain; no enable, load or terminal-count outputs.

Parameters:
- SEQ_MODE, 0, sequence select: 0 = binary up, 1 = binary down, 2 = Gray-code up, 3 = 3-bit Johnson (twisted ring).
- Any other SEQ_MODE value behaves as 0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset/clear.
- q  output  3  current counter state, driven directly from a register (no combinational path from inputs).

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high.
- Power-up value of q is 3'b000 (register initializer), so q is defined before the first clr.
- On a rising clk edge with clr = 1: q <= 3'b000 for every SEQ_MODE. clr has priority over counting.
- While clr is held high, q stays 000 on every edge.
- On a rising clk edge with clr = 0: q <= next(q), using the table for the selected mode.
- Mode 0, binary up: 000→001→010→011→100→101→110→111→000 (wraps 7→0).
- Mode 1, binary down: 000→111→110→101→100→011→010→001→000 (wraps 0→7).
- Mode 2, Gray up: 000→001→011→010→110→111→101→100→000. Exactly one bit changes per step, including the wrap.
- Mode 3, Johnson: 000→001→011→111→110→100→000 (period 6).
- Mode 3 illegal states 010 and 101 must go to 000 on the next non-clear edge (self-recovery, no lock-up).
- Modes 0–2 have no illegal states. The case statement still includes a default arm that sends q to 000.
- Deasserting clr: the first edge with clr = 0 moves q from 000 to next(000). Counting resumes from 000, never from the pre-clear value.
- Reasserting clr mid-sequence: the next edge forces 000, whatever the current state.
- Latency: one clock from a clr change to its effect on q.
- Glitches on clr between edges have no effect.
- No outputs other than q. No X propagation: every case arm assigns all 3 bits.

Test Plan:
- SEQ_MODE=0, 20 ns clock, clr=0 from t=0 → starting at 000, q counts 001, 002… up to 111, then wraps to 000 on the 8th edge. Values at consecutive edges: 1,2,3,4,5,6,7,0.
- SEQ_MODE=0, clr=1 at t=100 ns held for 600 ns → q=000 at the first edge after 100 ns and stays 000 for all 30 edges.
- Continue the previous case: clr=0 at t=700 ns, then clr=1 at t=1000 ns → q=001 on the first edge after 700 ns, counts up through the 15 edges with wrap (…7,0,…), then returns to 000 on the first edge after 1000 ns.
- SEQ_MODE=1 after a clear → q goes 111,110,…,001,000,111. Covers the 0→7 wrap.
- SEQ_MODE=2 → q follows 001,011,010,110,111,101,100,000. The bench checks popcount(q xor q_prev)=1 on every step.
- SEQ_MODE=3: force q=010 (and separately 101) via hierarchical deposit with clr=0 → q=000 on the next edge, then 001,011,111,110,100,000 (period 6).

Source files
------------

// File: rtl/ct_case_counter.sv
// 3-bit sequence counter: next state comes from a per-mode lookup table, not an adder.
// SEQ_MODE: 0 binary up, 1 binary down, 2 Gray up, 3 Johnson; other values act as 0.
module ct_case_counter #(
    parameter int SEQ_MODE = 0
) (
    input  logic       clk,
    input  logic       clr,
    output logic [2:0] q
);

    localparam int unsigned W = 3;
    localparam int MODE = (SEQ_MODE >= 1 && SEQ_MODE <= 3) ? SEQ_MODE : 0;

    // Initializer gives a defined value before the first clear.
    logic [W-1:0] q_r = '0;
    logic [W-1:0] q_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= '0;
        end else begin
            q_r <= q_next;
        end
    end

    assign q = q_r;

    // Next-state table; every arm assigns all bits, and unlisted Johnson states recover to 000.
    always_comb begin
        q_next = '0;
        case (MODE)
            1: begin
                case (q_r)
                    3'b000:  q_next = 3'b111;
                    3'b111:  q_next = 3'b110;
                    3'b110:  q_next = 3'b101;
                    3'b101:  q_next = 3'b100;
                    3'b100:  q_next = 3'b011;
                    3'b011:  q_next = 3'b010;
                    3'b010:  q_next = 3'b001;
                    3'b001:  q_next = 3'b000;
                    default: q_next = 3'b000;
                endcase
            end
            2: begin
                case (q_r)
                    3'b000:  q_next = 3'b001;
                    3'b001:  q_next = 3'b011;
                    3'b011:  q_next = 3'b010;
                    3'b010:  q_next = 3'b110;
                    3'b110:  q_next = 3'b111;
                    3'b111:  q_next = 3'b101;
                    3'b101:  q_next = 3'b100;
                    3'b100:  q_next = 3'b000;
                    default: q_next = 3'b000;
                endcase
            end
            3: begin
                case (q_r)
                    3'b000:  q_next = 3'b001;
                    3'b001:  q_next = 3'b011;
                    3'b011:  q_next = 3'b111;
                    3'b111:  q_next = 3'b110;
                    3'b110:  q_next = 3'b100;
                    3'b100:  q_next = 3'b000;
                    default: q_next = 3'b000;
                endcase
            end
            default: begin
                case (q_r)
                    3'b000:  q_next = 3'b001;
                    3'b001:  q_next = 3'b010;
                    3'b010:  q_next = 3'b011;
                    3'b011:  q_next = 3'b100;
                    3'b100:  q_next = 3'b101;
                    3'b101:  q_next = 3'b110;
                    3'b110:  q_next = 3'b111;
                    3'b111:  q_next = 3'b000;
                    default: q_next = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_ct_case_counter.sv
// Bench for ct_case_counter: five instances (modes 0,1,2,3 and out-of-range 5) share clk/clr
// and are compared against an arithmetic reference model after every edge.
module tb_ct_case_counter;

    logic       clk = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] qv [5];
    logic [2:0] m  [5];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #10 clk = ~clk;

    ct_case_counter #(.SEQ_MODE(0)) dut0 (.clk(clk), .clr(clr), .q(qv[0]));
    ct_case_counter #(.SEQ_MODE(1)) dut1 (.clk(clk), .clr(clr), .q(qv[1]));
    ct_case_counter #(.SEQ_MODE(2)) dut2 (.clk(clk), .clr(clr), .q(qv[2]));
    ct_case_counter #(.SEQ_MODE(3)) dut3 (.clk(clk), .clr(clr), .q(qv[3]));
    ct_case_counter #(.SEQ_MODE(5)) dut4 (.clk(clk), .clr(clr), .q(qv[4]));

    function automatic int mode_of(input int i);
        return (i == 4) ? 5 : i;
    endfunction

    function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Reference: plain arithmetic for up/down/Gray, a ring list for Johnson.
    function automatic logic [2:0] model_next(input int mode, input logic [2:0] cur);
        logic [2:0] ring [6];
        logic [2:0] b;
        ring = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4};
        case (mode)
            1: return 3'((int'(cur) + 7) % 8);
            2: begin
                b = 3'((int'(gray_to_bin(cur)) + 1) % 8);
                return b ^ (b >> 1);
            end
            3: begin
                for (int k = 0; k < 6; k++)
                    if (ring[k] == cur) return ring[(k + 1) % 6];
                return 3'd0;
            end
            default: return 3'((int'(cur) + 1) % 8);
        endcase
    endfunction

    // Drive clr from a falling edge, take one rising edge, return at the next falling edge.
    task automatic do_step(input logic c);
        clr = c;
        @(posedge clk);
        for (int i = 0; i < 5; i++) m[i] = c ? 3'd0 : model_next(mode_of(i), m[i]);
        @(negedge clk);
    endtask

    task automatic test_powerup;
        #1;
        for (int i = 0; i < 5; i++) begin
            m[i] = 3'd0;
            n_checks++;
            if (qv[i] !== m[i]) $display("FAIL powerup mode=%0d got=%b exp=%b", mode_of(i), qv[i], m[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_count_from_powerup;
        for (int s = 0; s < 8; s++) begin
            do_step(1'b0);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (qv[i] !== m[i]) $display("FAIL count_powerup step=%0d mode=%0d got=%b exp=%b", s, mode_of(i), qv[i], m[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset;
        do_step(1'b0);
        do_step(1'b0);
        for (int s = 0; s < 30; s++) begin
            do_step(1'b1);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (qv[i] !== 3'd0) $display("FAIL reset_hold step=%0d mode=%0d got=%b exp=000", s, mode_of(i), qv[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_resume_and_wrap;
        for (int s = 0; s < 15; s++) begin
            do_step(1'b0);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (qv[i] !== m[i]) $display("FAIL resume step=%0d mode=%0d got=%b exp=%b", s, mode_of(i), qv[i], m[i]);
                else n_pass++;
            end
        end
        do_step(1'b1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (qv[i] !== 3'd0) $display("FAIL reclear mode=%0d got=%b exp=000", mode_of(i), qv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_gray_one_bit;
        logic [2:0] prev;
        do_step(1'b1);
        for (int s = 0; s < 9; s++) begin
            prev = qv[2];
            do_step(1'b0);
            n_checks++;
            if ($countones(qv[2] ^ prev) != 1)
                $display("FAIL gray_onebit step=%0d got=%b prev=%b exp_bits_changed=1", s, qv[2], prev);
            else n_pass++;
            n_checks++;
            if (qv[2] !== m[2]) $display("FAIL gray_seq step=%0d got=%b exp=%b", s, qv[2], m[2]);
            else n_pass++;
        end
    endtask

    task automatic test_johnson_recovery;
        logic [2:0] bad [2];
        bad = '{3'b010, 3'b101};
        for (int b = 0; b < 2; b++) begin
            do_step(1'b1);
            dut3.q_r = bad[b];
            m[3] = bad[b];
            #1;
            n_checks++;
            if (qv[3] !== bad[b]) $display("FAIL johnson_deposit got=%b exp=%b", qv[3], bad[b]);
            else n_pass++;
            for (int s = 0; s < 7; s++) begin
                do_step(1'b0);
                n_checks++;
                if (qv[3] !== m[3]) $display("FAIL johnson_recover from=%b step=%0d got=%b exp=%b", bad[b], s, qv[3], m[3]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_glitch;
        do_step(1'b0);
        for (int s = 0; s < 4; s++) begin
            clr = 1'b1;
            #3;
            clr = 1'b0;
            do_step(1'b0);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (qv[i] !== m[i]) $display("FAIL clr_glitch step=%0d mode=%0d got=%b exp=%b", s, mode_of(i), qv[i], m[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random;
        logic c;
        for (int s = 0; s < 300; s++) begin
            c = ($urandom_range(0, 7) == 0);
            do_step(c);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (qv[i] !== m[i]) $display("FAIL random step=%0d clr=%0b mode=%0d got=%b exp=%b", s, c, mode_of(i), qv[i], m[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_powerup;
        test_count_from_powerup;
        test_reset;
        test_resume_and_wrap;
        test_gray_one_bit;
        test_johnson_recovery;
        test_glitch;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
